// File: rtl/oled_spi_tx.sv
// SPI transmit engine for the PmodOLEDrgb: serializes one command byte or one
// RGB565 pixel word per handshake, MSB first, framed by cs, with dc per transfer.
module oled_spi_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_two_bytes,
    input  logic        tx_is_cmd,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    output logic        cs,
    output logic        dc
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  phase, phase_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [15:0] shreg, shreg_n;
    logic        two_q, two_n;
    logic        sclk_n, mosi_n, cs_n, dc_n, done_n;
    logic        phase_end;
    logic        last_bit;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        two_n     = two_q;
        sclk_n    = sclk;
        mosi_n    = mosi;
        cs_n      = cs;
        dc_n      = dc;
        done_n    = 1'b0;
        phase_end = (phase == PH_LAST);
        last_bit  = (bit_cnt == (two_q ? 5'd15 : 5'd7));

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n   = SETUP;
                    phase_n   = '0;
                    bit_cnt_n = '0;
                    two_n     = tx_two_bytes;
                    dc_n      = ~tx_is_cmd;
                    cs_n      = 1'b0;
                    sclk_n    = 1'b0;
                    // 8-bit payloads are left-aligned so bit 15 is always next out
                    shreg_n   = tx_two_bytes ? tx_data : {tx_data[7:0], 8'h00};
                    mosi_n    = tx_two_bytes ? tx_data[15] : tx_data[7];
                end
            end
            SETUP: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = SHIFT;
                    sclk_n  = 1'b1;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            SHIFT: begin
                if (!phase_end) begin
                    phase_n = phase + 8'd1;
                end else begin
                    phase_n = '0;
                    if (sclk) begin
                        sclk_n = 1'b0;
                    end else if (last_bit) begin
                        state_n = GAP;
                        cs_n    = 1'b1;
                        mosi_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        // next bit is presented on the rising edge, held across the fall
                        bit_cnt_n = bit_cnt + 5'd1;
                        sclk_n    = 1'b1;
                        shreg_n   = {shreg[14:0], 1'b0};
                        mosi_n    = shreg[14];
                    end
                end
            end
            GAP: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = IDLE;
                end else begin
                    phase_n = phase + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            two_q    <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
            dc       <= 1'b1;
            done     <= 1'b0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            two_q    <= two_n;
            sclk     <= sclk_n;
            mosi     <= mosi_n;
            cs       <= cs_n;
            dc       <= dc_n;
            done     <= done_n;
            tx_ready <= (state_n == IDLE);
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: three instances (CLK_DIV 1, 2, 4) checked every cycle
// against a pin-timing model derived from the accept cycle, plus an SPI receiver.
module tb_oled_spi_tx;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic        tx_valid [NI];
    logic [15:0] tx_data  [NI];
    logic        tx_two   [NI];
    logic        tx_cmd   [NI];
    logic        ready_o  [NI];
    logic        busy_o   [NI];
    logic        done_o   [NI];
    logic        sclk_o   [NI];
    logic        mosi_o   [NI];
    logic        cs_o     [NI];
    logic        dc_o     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        oled_spi_tx #(.CLK_DIV((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .tx_valid    (tx_valid[g]),
            .tx_ready    (ready_o[g]),
            .tx_data     (tx_data[g]),
            .tx_two_bytes(tx_two[g]),
            .tx_is_cmd   (tx_cmd[g]),
            .busy        (busy_o[g]),
            .done        (done_o[g]),
            .sclk        (sclk_o[g]),
            .mosi        (mosi_o[g]),
            .cs          (cs_o[g]),
            .dc          (dc_o[g])
        );
    end

    int total = 0;
    int bad = 0;
    int nprint = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (nprint < 60) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
            nprint++;
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    // model: a transfer is fully described by its accept cycle, word, length and dc
    int          cyc = 0;
    int          acc     [NI] = '{default: 0};
    int          acc_cnt [NI] = '{default: 0};
    bit          active  [NI] = '{default: 0};
    logic [15:0] mw      [NI] = '{default: '0};
    int          mn      [NI] = '{default: 8};
    logic        mdc     [NI] = '{default: 1'b1};

    always @(posedge clk) begin
        int d;
        bit rdy;
        for (int i = 0; i < NI; i++) begin
            d = div_of(i);
            rdy = !active[i] || ((cyc - acc[i] + 1) >= 1 + d * (2 + 2 * mn[i]));
            if (!resetn) begin
                active[i] = 0;
                mdc[i] = 1'b1;
            end else if (rdy && tx_valid[i]) begin
                active[i] = 1;
                acc[i] = cyc + 1;
                acc_cnt[i]++;
                mw[i] = tx_two[i] ? tx_data[i] : {tx_data[i][7:0], 8'h00};
                mn[i] = tx_two[i] ? 16 : 8;
                mdc[i] = ~tx_cmd[i];
            end
        end
        cyc++;
    end

    // returns {cs, sclk, mosi, done, tx_ready} for the current cycle
    function automatic logic [4:0] expect_pins(input int i);
        int d, n, m, nn;
        logic e_cs, e_sclk, e_mosi, e_done, e_rdy;
        if (!resetn || !active[i]) return 5'b10001;
        d = div_of(i);
        nn = mn[i];
        n = cyc - acc[i] + 1;
        m = n - 1 - d;
        e_cs = !(n >= 1 && n <= d * (1 + 2 * nn));
        e_done = (n == 1 + d * (1 + 2 * nn));
        e_rdy = (n >= 1 + d * (2 + 2 * nn));
        e_sclk = 1'b0;
        e_mosi = 1'b0;
        if (n >= 1 && n <= d) begin
            e_mosi = mw[i][15];
        end else if (m >= 0 && m < 2 * nn * d) begin
            e_sclk = (m % (2 * d)) < d;
            e_mosi = mw[i][15 - m / (2 * d)];
        end
        return {e_cs, e_sclk, e_mosi, e_done, e_rdy};
    endfunction

    int          fall_cnt    [NI] = '{default: 0};
    int          done_cnt    [NI] = '{default: 0};
    int          done_cyc    [NI] = '{default: 0};
    int          rdy_cyc     [NI] = '{default: 0};
    int          cs_fall_cyc [NI] = '{default: 0};
    int          cs_rise_cyc [NI] = '{default: 0};
    int          last_fall   [NI] = '{default: -1000};
    int          last_chg    [NI] = '{default: -1000};
    logic        prev_sclk   [NI] = '{default: 1'b0};
    logic        prev_mosi   [NI] = '{default: 1'b0};
    logic        prev_cs     [NI] = '{default: 1'b1};
    logic        prev_rdy    [NI] = '{default: 1'b1};
    int          rx_bits     [NI] = '{default: 0};
    logic [7:0]  rx_sh       [NI] = '{default: '0};
    logic [7:0]  cap         [NI][32];
    int          cap_cnt     [NI] = '{default: 0};

    always @(negedge clk) begin
        logic [4:0] e;
        int d;
        for (int i = 0; i < NI; i++) begin
            e = expect_pins(i);
            d = div_of(i);
            chk($sformatf("cs[%0d]", i), cs_o[i], e[4]);
            chk($sformatf("sclk[%0d]", i), sclk_o[i], e[3]);
            chk($sformatf("mosi[%0d]", i), mosi_o[i], e[2]);
            chk($sformatf("done[%0d]", i), done_o[i], e[1]);
            chk($sformatf("tx_ready[%0d]", i), ready_o[i], e[0]);
            chk($sformatf("busy[%0d]", i), busy_o[i], !e[0]);
            chk($sformatf("dc[%0d]", i), dc_o[i], resetn ? mdc[i] : 1'b1);

            if (mosi_o[i] != prev_mosi[i]) begin
                if (resetn) chk($sformatf("mosi_hold[%0d]", i), (cyc - last_fall[i]) >= d, 1);
                last_chg[i] = cyc;
            end
            if (!prev_sclk[i] && sclk_o[i])
                chk($sformatf("cs_setup[%0d]", i), (cyc - cs_fall_cyc[i]) >= d, 1);
            if (prev_sclk[i] && !sclk_o[i] && !cs_o[i]) begin
                chk($sformatf("mosi_setup[%0d]", i), (cyc - last_chg[i]) >= d, 1);
                last_fall[i] = cyc;
                fall_cnt[i]++;
                rx_sh[i] = {rx_sh[i][6:0], mosi_o[i]};
                rx_bits[i]++;
                if (rx_bits[i] == 8) begin
                    if (cap_cnt[i] < 32) cap[i][cap_cnt[i]] = rx_sh[i];
                    cap_cnt[i]++;
                    rx_bits[i] = 0;
                end
            end
            if (cs_o[i]) rx_bits[i] = 0;
            if (prev_cs[i] && !cs_o[i]) cs_fall_cyc[i] = cyc;
            if (!prev_cs[i] && cs_o[i]) cs_rise_cyc[i] = cyc;
            if (!prev_rdy[i] && ready_o[i]) rdy_cyc[i] = cyc;
            if (done_o[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            prev_sclk[i] = sclk_o[i];
            prev_mosi[i] = mosi_o[i];
            prev_cs[i] = cs_o[i];
            prev_rdy[i] = ready_o[i];
        end
    end

    task automatic wait_acc(input int i, input int c0);
        int k = 0;
        while (acc_cnt[i] == c0 && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (acc_cnt[i] == c0) chk("accept_timeout", acc_cnt[i], c0 + 1);
    endtask

    task automatic wait_done(input int i, input int c0);
        int k = 0;
        while (done_cnt[i] == c0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt[i] == c0) chk("done_timeout", done_cnt[i], c0 + 1);
    endtask

    task automatic send(input int i, input logic [15:0] d, input logic two, input logic cmd);
        int c0;
        c0 = acc_cnt[i];
        @(posedge clk);
        #1;
        tx_valid[i] = 1'b1;
        tx_data[i] = d;
        tx_two[i] = two;
        tx_cmd[i] = cmd;
        wait_acc(i, c0);
        tx_valid[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, bf, dn, a1, a2, r1, c0, k;
        for (int i = 0; i < NI; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i] = '0;
            tx_two[i] = 1'b0;
            tx_cmd[i] = 1'b0;
        end
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_cs", cs_o[i], 1);
            chk("rst_sclk", sclk_o[i], 0);
            chk("rst_mosi", mosi_o[i], 0);
            chk("rst_dc", dc_o[i], 1);
            chk("rst_ready", ready_o[i], 1);
        end
        resetn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk("idle_falls", fall_cnt[i], 0);

        // pixel, CLK_DIV = 2
        bc = cap_cnt[1];
        bf = fall_cnt[1];
        dn = done_cnt[1];
        send(1, 16'hF81F, 1'b1, 1'b0);
        wait_done(1, dn);
        repeat (5) @(negedge clk);
        chk("px_nbytes", cap_cnt[1] - bc, 2);
        chk("px_byte0", cap[1][bc], 8'hF8);
        chk("px_byte1", cap[1][bc + 1], 8'h1F);
        chk("px_falls", fall_cnt[1] - bf, 16);
        chk("px_done_cyc", done_cyc[1] - acc[1] + 1, 67);
        chk("px_ready_cyc", rdy_cyc[1] - acc[1] + 1, 69);
        chk("px_dc", dc_o[1], 1);

        // command, CLK_DIV = 1
        bc = cap_cnt[0];
        bf = fall_cnt[0];
        dn = done_cnt[0];
        send(0, 16'h00AF, 1'b0, 1'b1);
        wait_done(0, dn);
        repeat (4) @(negedge clk);
        chk("cmd_nbytes", cap_cnt[0] - bc, 1);
        chk("cmd_byte", cap[0][bc], 8'hAF);
        chk("cmd_falls", fall_cnt[0] - bf, 8);
        chk("cmd_dc", dc_o[0], 0);
        chk("cmd_cs_first", cs_fall_cyc[0] - acc[0] + 1, 1);
        chk("cmd_cs_rise", cs_rise_cyc[0] - acc[0] + 1, 18);

        // back-to-back, CLK_DIV = 4, valid held high
        bc = cap_cnt[2];
        bf = fall_cnt[2];
        c0 = acc_cnt[2];
        @(posedge clk);
        #1;
        tx_valid[2] = 1'b1;
        tx_data[2] = 16'h1234;
        tx_two[2] = 1'b1;
        tx_cmd[2] = 1'b0;
        wait_acc(2, c0);
        a1 = acc[2];
        tx_data[2] = 16'hABCD;
        wait_acc(2, c0 + 1);
        a2 = acc[2];
        r1 = cs_rise_cyc[2];
        tx_valid[2] = 1'b0;
        tx_data[2] = 16'h0F0F;
        dn = done_cnt[2];
        wait_done(2, dn);
        repeat (6) @(negedge clk);
        chk("b2b_period", a2 - a1, 137);
        chk("b2b_cs_high", cs_fall_cyc[2] - r1, 5);
        chk("b2b_nbytes", cap_cnt[2] - bc, 4);
        chk("b2b_byte0", cap[2][bc], 8'h12);
        chk("b2b_byte1", cap[2][bc + 1], 8'h34);
        chk("b2b_byte2", cap[2][bc + 2], 8'hAB);
        chk("b2b_byte3", cap[2][bc + 3], 8'hCD);
        chk("b2b_falls", fall_cnt[2] - bf, 32);

        // reset after the 5th falling edge, then a clean word
        bf = fall_cnt[2];
        dn = done_cnt[2];
        send(2, 16'hA5F0, 1'b1, 1'b0);
        k = 0;
        while (fall_cnt[2] < bf + 5 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reach_fall5", fall_cnt[2] - bf, 5);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_cs", cs_o[2], 1);
        chk("abort_sclk", sclk_o[2], 0);
        chk("abort_mosi", mosi_o[2], 0);
        chk("abort_ready", ready_o[2], 1);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt[2], dn);
        bc = cap_cnt[2];
        send(2, 16'h5555, 1'b1, 1'b0);
        wait_done(2, dn);
        repeat (6) @(negedge clk);
        chk("resume_nbytes", cap_cnt[2] - bc, 2);
        chk("resume_byte0", cap[2][bc], 8'h55);
        chk("resume_byte1", cap[2][bc + 1], 8'h55);
        chk("resume_done", done_cnt[2], dn + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
